uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: 16-byte transmit FIFO feeding a UART transmitter.
// Launches one byte per transmitter busy cycle and flags drops and drain completion.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       flush,
  input  logic       clr_ovf,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [4:0] count,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       irq_done,
  output logic       q_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SEND   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          irq_q, irq_d;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic          push_ok;
  logic          push_drop;
  logic          pop;
  logic          send_done;

  // Qualify the queue-side events for this cycle.
  always_comb begin
    push_ok   = wr_en & ~full_q & ~flush;
    push_drop = wr_en & full_q & ~flush;
    pop       = (state_q == IDLE) & ~empty_q & ~tx_busy;
    send_done = (state_q == SEND) & ~tx_busy;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: launch, wait for busy, wait for idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: launch pulse, held byte and drain interrupt.
  always_comb begin
    tx_start_d = pop;
    tx_data_d  = tx_data_q;
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
    end
    irq_d = send_done & (count_q == 5'd0) & ~push_ok;
  end

  // Pointer, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
      count_d  = count_q + {4'b0, push_ok} - {4'b0, pop};
    end
    empty_d = (count_d == 5'd0);
    full_d  = (count_d == 5'(DEPTH));
    ovf_d   = ovf_q;
    if (push_drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Buffer write port.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      irq_q      <= irq_d;
    end
  end

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = ovf_q;
  assign irq_done = irq_q;
  assign q_busy   = (state_q != IDLE) | ~empty_q;

endmodule
